// File: rtl/max1452_pkg.sv
// Shared definitions for the MAX1452 configuration/scan sequencer:
// FSM state encoding, the fixed configuration byte script and the
// mux_sel field layout.
package max1452_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG_SEND,
    S_SETTLE,
    S_CONV,
    S_WAIT_ADC
  } state_e;

  // Configuration script: config reg, FSODAC, ODAC, OTCDAC, terminator 0xFA.
  localparam int SCRIPT_LEN = 26;
  localparam int IDX_W      = $clog2(SCRIPT_LEN);

  localparam logic [0:SCRIPT_LEN-1][7:0] CFG_SCRIPT = {
    8'h01, 8'hF0, 8'h11, 8'h42, 8'h13, 8'h06, 8'h09, 8'h30, 8'h31,
    8'h32, 8'h33, 8'h36, 8'h09, 8'h00, 8'h01, 8'h02, 8'h03, 8'h16,
    8'h09, 8'h00, 8'h01, 8'h02, 8'h03, 8'h26, 8'h09, 8'hFA
  };

  // mux_sel = {F3, F2, F1}, three bits per stage of the 8:1 mux tree.
  localparam int MUX_F1_LSB = 0;
  localparam int MUX_F2_LSB = 3;
  localparam int MUX_F3_LSB = 6;

  function automatic logic [7:0] cfg_byte(input logic [IDX_W-1:0] i);
    return (int'(i) < SCRIPT_LEN) ? CFG_SCRIPT[i] : 8'h00;
  endfunction

  function automatic logic [8:0] mux_word(input logic [2:0] f3, input logic [5:0] ch);
    logic [8:0] w;
    w = '0;
    w[MUX_F3_LSB +: 3] = f3;
    w[MUX_F2_LSB +: 3] = ch[5:3];
    w[MUX_F1_LSB +: 3] = ch[2:0];
    return w;
  endfunction

endpackage

// File: rtl/max1452_seq_timer.sv
// Loadable down-counter shared by the mux settle delay and the ADC timeout.
// expired_o is high while the count is 1, i.e. during the last cycle of a
// loaded interval of val_i cycles (the load cycle itself is not counted).
module max1452_seq_timer #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;

  // Load has priority; otherwise count down and park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt_q <= '0;
    else if (load_i)        cnt_q <= val_i;
    else if (cnt_q != '0)   cnt_q <= cnt_q - 1'b1;
  end

  assign expired_o = (cnt_q == W'(1));

endmodule

// File: rtl/max1452_cfg_scan_ctrl.sv
// MAX1452 bench sequencer: streams the configuration script to the UART
// transmitter, then scans the mux tree channel by channel, triggering the
// LTC2315 and capturing samples. Script length comes from max1452_pkg.
// Optional feature macro: MAX1452_UNLOCK_CTRL_EN (drives UNLOCK low once
// configuration is complete; otherwise UNLOCK is tied high).
module max1452_cfg_scan_ctrl
  import max1452_pkg::*;
#(
  parameter int         NUM_CH     = 8,
  parameter logic [2:0] F3_SEL     = 3'd0,
  parameter int         SETTLE_CYC = 1000,
  parameter int         ADC_TO_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [8:0]  mux_sel,
  output logic        adc_start,
  input  logic        adc_done,
  input  logic [11:0] adc_data,
  output logic [11:0] sample_data,
  output logic [5:0]  sample_ch,
  output logic        sample_valid,
  output logic        scan_wrap,
  output logic        cfg_done,
  output logic        adc_err,
  output logic        unlock
);

  localparam int TMR_MAX = (SETTLE_CYC > ADC_TO_CYC) ? SETTLE_CYC : ADC_TO_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC);
  localparam logic [TMR_W-1:0] ADC_LD    = TMR_W'(ADC_TO_CYC);
  localparam logic [5:0]       LAST_CH   = 6'(NUM_CH - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SCRIPT_LEN - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [5:0]        ch_q, ch_d, ch_nxt;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic [8:0]        mux_sel_q, mux_sel_d;
  logic [11:0]       sample_data_q, sample_data_d;
  logic [5:0]        sample_ch_q, sample_ch_d;
  logic              sample_valid_q, sample_valid_d;
  logic              scan_wrap_q, scan_wrap_d;
  logic              cfg_done_q, cfg_done_d;
  logic              adc_err_q, adc_err_d;
  logic              tmr_load, tmr_exp;
  logic [TMR_W-1:0]  tmr_val;
  logic              tx_fire, last_byte, wait_end;

  assign tx_fire   = tx_valid_q & tx_ready;
  assign last_byte = (idx_q == LAST_IDX);
  // adc_done takes precedence over a simultaneous timeout expiry.
  assign wait_end  = adc_done | tmr_exp;
  assign ch_nxt    = (ch_q == LAST_CH) ? 6'd0 : ch_q + 6'd1;

  max1452_seq_timer #(.W(TMR_W)) u_tmr (
    .clk       (clk),
    .rst       (rst),
    .load_i    (tmr_load),
    .val_i     (tmr_val),
    .expired_o (tmr_exp)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; stop aborts the scan states but not configuration.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start) state_d = S_CFG_SEND;
      S_CFG_SEND: if (tx_fire && last_byte) state_d = S_SETTLE;
      S_SETTLE:   if (stop) state_d = S_IDLE; else if (tmr_exp) state_d = S_CONV;
      S_CONV:     state_d = stop ? S_IDLE : S_WAIT_ADC;
      S_WAIT_ADC: if (stop) state_d = S_IDLE; else if (wait_end) state_d = S_SETTLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Output / datapath next-values and the shared timer loads.
  always_comb begin
    idx_d          = idx_q;
    ch_d           = ch_q;
    tx_data_d      = tx_data_q;
    tx_valid_d     = tx_valid_q;
    mux_sel_d      = mux_sel_q;
    sample_data_d  = sample_data_q;
    sample_ch_d    = sample_ch_q;
    sample_valid_d = 1'b0;
    scan_wrap_d    = 1'b0;
    cfg_done_d     = cfg_done_q;
    adc_err_d      = adc_err_q;
    tmr_load       = 1'b0;
    tmr_val        = SETTLE_LD;
    adc_start      = (state_q == S_CONV);
    case (state_q)
      S_IDLE: if (start) begin
        idx_d      = '0;
        tx_valid_d = 1'b1;
        tx_data_d  = cfg_byte('0);
        cfg_done_d = 1'b0;
        adc_err_d  = 1'b0;
      end
      S_CFG_SEND: if (tx_fire) begin
        if (!last_byte) begin
          idx_d     = idx_q + 1'b1;
          tx_data_d = cfg_byte(idx_q + 1'b1);
        end else begin
          tx_valid_d = 1'b0;
          cfg_done_d = 1'b1;
          ch_d       = 6'd0;
          mux_sel_d  = mux_word(F3_SEL, 6'd0);
          tmr_load   = 1'b1;
        end
      end
      S_CONV: if (!stop) begin
        tmr_load = 1'b1;
        tmr_val  = ADC_LD;
      end
      S_WAIT_ADC: if (!stop && wait_end) begin
        if (adc_done) begin
          sample_data_d  = adc_data;
          sample_ch_d    = ch_q;
          sample_valid_d = 1'b1;
        end else begin
          adc_err_d = 1'b1;
        end
        scan_wrap_d = (ch_q == LAST_CH);
        ch_d        = ch_nxt;
        mux_sel_d   = mux_word(F3_SEL, ch_nxt);
        tmr_load    = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath / registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q          <= '0;
      ch_q           <= '0;
      tx_data_q      <= '0;
      tx_valid_q     <= 1'b0;
      mux_sel_q      <= mux_word(F3_SEL, 6'd0);
      sample_data_q  <= '0;
      sample_ch_q    <= '0;
      sample_valid_q <= 1'b0;
      scan_wrap_q    <= 1'b0;
      cfg_done_q     <= 1'b0;
      adc_err_q      <= 1'b0;
    end else begin
      idx_q          <= idx_d;
      ch_q           <= ch_d;
      tx_data_q      <= tx_data_d;
      tx_valid_q     <= tx_valid_d;
      mux_sel_q      <= mux_sel_d;
      sample_data_q  <= sample_data_d;
      sample_ch_q    <= sample_ch_d;
      sample_valid_q <= sample_valid_d;
      scan_wrap_q    <= scan_wrap_d;
      cfg_done_q     <= cfg_done_d;
      adc_err_q      <= adc_err_d;
    end
  end

  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;
  assign mux_sel      = mux_sel_q;
  assign sample_data  = sample_data_q;
  assign sample_ch    = sample_ch_q;
  assign sample_valid = sample_valid_q;
  assign scan_wrap    = scan_wrap_q;
  assign cfg_done     = cfg_done_q;
  assign adc_err      = adc_err_q;

`ifdef MAX1452_UNLOCK_CTRL_EN
  logic unlock_q, unlock_d;

  // UNLOCK goes low the cycle after cfg_done rises; a new start re-arms it.
  always_comb begin
    unlock_d = unlock_q;
    if (state_q == S_IDLE && start) unlock_d = 1'b1;
    else if (cfg_done_q)            unlock_d = 1'b0;
  end

  // UNLOCK register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) unlock_q <= 1'b1;
    else     unlock_q <= unlock_d;
  end

  assign unlock = unlock_q;
`else
  assign unlock = 1'b1;
`endif

endmodule

// File: tb/tb_max1452_cfg_scan_ctrl.sv
// Directed bench for max1452_cfg_scan_ctrl: script streaming with and without
// tx back-pressure, full scan pass, ADC timeout, stop and reset aborts, UNLOCK.
module tb_max1452_cfg_scan_ctrl;

  localparam int         NUM_CH     = 8;
  localparam logic [2:0] F3_SEL     = 3'd5;
  localparam int         SETTLE_CYC = 10;
  localparam int         ADC_TO_CYC = 40;
  localparam int         ADC_LAT    = 20;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
  logic        tx_ready = 1'b0, adc_done = 1'b0;
  logic [11:0] adc_data = '0;
  logic [7:0]  tx_data;
  logic        tx_valid, adc_start, sample_valid, scan_wrap, cfg_done, adc_err, unlock;
  logic [8:0]  mux_sel;
  logic [11:0] sample_data;
  logic [5:0]  sample_ch;

  max1452_cfg_scan_ctrl #(
    .NUM_CH(NUM_CH), .F3_SEL(F3_SEL), .SETTLE_CYC(SETTLE_CYC), .ADC_TO_CYC(ADC_TO_CYC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mux_sel(mux_sel), .adc_start(adc_start), .adc_done(adc_done), .adc_data(adc_data),
    .sample_data(sample_data), .sample_ch(sample_ch), .sample_valid(sample_valid),
    .scan_wrap(scan_wrap), .cfg_done(cfg_done), .adc_err(adc_err), .unlock(unlock)
  );

  always #5 clk = ~clk;

  typedef struct { logic [11:0] data; logic [5:0] ch; logic wrap; int cyc; } smp_t;
  typedef struct { int cyc; logic [8:0] mux; } st_t;
  // Vector record: ADC behaviour for the channel (input) and expected sample.
  typedef struct { logic silent; logic [5:0] exp_ch; logic [11:0] exp_data; logic exp_wrap; } vec_t;

  int   n_chk = 0, n_fail = 0, cyc = 0, silent_ch = -1;
  int   cfg_rise_cyc = 0, err_rise_cyc = 0, wrap_cnt = 0, unlock_viol = 0;
  logic [7:0] tx_q[$];
  int         tx_cyc_q[$];
  smp_t       smp_q[$];
  st_t        st_q[$];
  logic       prev_stall = 0, prev_cfg = 0, prev_err = 0, cfg_rose_last = 0;
  logic [7:0] prev_data = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_tx_valid"}, tx_valid, 0);
    check({tag, "_mux_sel"}, mux_sel, 9'h140);
    check({tag, "_adc_start"}, adc_start, 0);
    check({tag, "_sample_data"}, sample_data, 0);
    check({tag, "_sample_ch"}, sample_ch, 0);
    check({tag, "_sample_valid"}, sample_valid, 0);
    check({tag, "_scan_wrap"}, scan_wrap, 0);
    check({tag, "_cfg_done"}, cfg_done, 0);
    check({tag, "_adc_err"}, adc_err, 0);
    check({tag, "_unlock"}, unlock, 1);
  endtask

  task automatic pulse(input logic s, input logic p);
    @(posedge clk); #1 start = s; stop = p;
    @(posedge clk); #1 start = 0; stop = 0;
  endtask

  task automatic clear_q();
    tx_q.delete(); tx_cyc_q.delete(); smp_q.delete(); st_q.delete(); wrap_cnt = 0;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: replies 0x100+ch ADC_LAT cycles after the request unless silenced.
  initial begin : adc_model
    logic [5:0] ch;
    forever begin
      @(negedge clk);
      if (adc_start && !rst) begin
        ch = mux_sel[5:0];
        if (int'(ch) != silent_ch) begin
          repeat (ADC_LAT) @(posedge clk);
          #1 adc_done = 1; adc_data = 12'h100 + {6'd0, ch};
          @(posedge clk); #1 adc_done = 0;
        end
      end
    end
  end

  // Monitor: logs transfers, samples and conversions; checks tx hold and UNLOCK.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0; prev_cfg = 0; prev_err = 0; cfg_rose_last = 0;
    end else begin
      if (tx_valid && tx_ready) begin tx_q.push_back(tx_data); tx_cyc_q.push_back(cyc); end
      if (prev_stall) begin
        check("tx_hold_valid", tx_valid, 1);
        check("tx_hold_data", tx_data, prev_data);
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (sample_valid) smp_q.push_back('{sample_data, sample_ch, scan_wrap, cyc});
      if (scan_wrap) wrap_cnt++;
      if (adc_start) st_q.push_back('{cyc, mux_sel});
      if (adc_err && !prev_err) err_rise_cyc = cyc;
`ifdef MAX1452_UNLOCK_CTRL_EN
      if (cfg_rose_last) check("unlock_low_after_cfg", unlock, 0);
      if (cfg_done && !prev_cfg) check("unlock_high_at_cfg", unlock, 1);
`else
      if (unlock !== 1'b1) unlock_viol++;
`endif
      cfg_rose_last = cfg_done && !prev_cfg;
      if (cfg_rose_last) cfg_rise_cyc = cyc;
      prev_cfg = cfg_done;
      prev_err = adc_err;
    end
  end

  initial begin
    logic [7:0] exp_script [26];
    vec_t v3 [8];
    vec_t v4 [7];
    int   ref_c;
    exp_script = '{8'h01, 8'hF0, 8'h11, 8'h42, 8'h13, 8'h06, 8'h09, 8'h30, 8'h31,
                   8'h32, 8'h33, 8'h36, 8'h09, 8'h00, 8'h01, 8'h02, 8'h03, 8'h16,
                   8'h09, 8'h00, 8'h01, 8'h02, 8'h03, 8'h26, 8'h09, 8'hFA};
    v3 = '{'{0, 6'd0, 12'h100, 0}, '{0, 6'd1, 12'h101, 0}, '{0, 6'd2, 12'h102, 0},
           '{0, 6'd3, 12'h103, 0}, '{0, 6'd4, 12'h104, 0}, '{0, 6'd5, 12'h105, 0},
           '{0, 6'd6, 12'h106, 0}, '{0, 6'd7, 12'h107, 1}};
    v4 = '{'{0, 6'd0, 12'h100, 0}, '{0, 6'd1, 12'h101, 0}, '{0, 6'd2, 12'h102, 0},
           '{0, 6'd4, 12'h104, 0}, '{0, 6'd5, 12'h105, 0}, '{0, 6'd6, 12'h106, 0},
           '{0, 6'd7, 12'h107, 1}};

    // Reset state
    repeat (3) @(negedge clk);
    check_reset("rst");
    @(posedge clk); #1 rst = 0;

    // 1 + 3: back-to-back script, then one full scan pass
    tx_ready = 1;
    pulse(1, 0);
    for (int i = 0; i < 100 && !cfg_done; i++) @(negedge clk);
    #1;
    check("t1_cfg_done", cfg_done, 1);
    check("t1_tx_valid_low", tx_valid, 0);
    check("t1_tx_count", tx_q.size(), 26);
    for (int i = 0; i < 26 && i < tx_q.size(); i++) check($sformatf("t1_byte%0d", i), tx_q[i], exp_script[i]);
    if (tx_cyc_q.size() == 26) check("t1_back_to_back", tx_cyc_q[25] - tx_cyc_q[0], 25);
    for (int i = 0; i < 400 && smp_q.size() < 8; i++) @(negedge clk);
    #1;
    pulse(0, 1);
    check("t3_sample_count", smp_q.size(), 8);
    for (int k = 0; k < 8 && k < smp_q.size() && k < st_q.size(); k++) begin
      check($sformatf("t3_ch%0d", k), smp_q[k].ch, v3[k].exp_ch);
      check($sformatf("t3_data%0d", k), smp_q[k].data, v3[k].exp_data);
      check($sformatf("t3_wrap%0d", k), smp_q[k].wrap, v3[k].exp_wrap);
      check($sformatf("t3_mux%0d", k), st_q[k].mux, {F3_SEL, v3[k].exp_ch});
      ref_c = (k == 0) ? cfg_rise_cyc : smp_q[k-1].cyc;
      check($sformatf("t3_settle%0d", k), st_q[k].cyc - ref_c, SETTLE_CYC);
    end
    repeat (40) @(negedge clk);
    check("t3_no_conv_after_stop", st_q.size(), 8);
    check("t3_mux_held", mux_sel, 9'h140);
    check("t3_cfg_kept", cfg_done, 1);
    check("t3_no_err", adc_err, 0);
    check("t3_wrap_cnt", wrap_cnt, 1);

    // 4: ADC silent on channel 3
    clear_q(); silent_ch = 3;
    pulse(1, 0);
    @(negedge clk);
    check("t4_cfg_cleared", cfg_done, 0);
    for (int i = 0; i < 800 && smp_q.size() < 7; i++) @(negedge clk);
    #1;
    pulse(0, 1);
    silent_ch = -1;
    check("t4_adc_err", adc_err, 1);
    check("t4_sample_count", smp_q.size(), 7);
    for (int k = 0; k < 7 && k < smp_q.size(); k++) begin
      check($sformatf("t4_ch%0d", k), smp_q[k].ch, v4[k].exp_ch);
      check($sformatf("t4_data%0d", k), smp_q[k].data, v4[k].exp_data);
      check($sformatf("t4_wrap%0d", k), smp_q[k].wrap, v4[k].exp_wrap);
    end
    if (st_q.size() >= 5) begin
      check("t4_mux_ch3", st_q[3].mux, 9'h143);
      check("t4_timeout_len", err_rise_cyc - st_q[3].cyc, ADC_TO_CYC + 1);
      check("t4_resume_ch4", st_q[4].mux, 9'h144);
      check("t4_resume_gap", st_q[4].cyc - err_rise_cyc, SETTLE_CYC);
    end else check("t4_conv_count", st_q.size(), 8);
    repeat (20) @(negedge clk);

    // 2: tx_ready one cycle in sixteen
    clear_q(); tx_ready = 0;
    pulse(1, 0);
    @(negedge clk);
    check("t2_err_cleared", adc_err, 0);
    check("t2_first_byte", tx_data, 8'h01);
    for (int i = 0; i < 26 * 16 + 50 && !cfg_done; i++) begin
      @(posedge clk); #1 tx_ready = ((i % 16) == 15);
    end
    tx_ready = 1;
    pulse(0, 1);
    check("t2_cfg_done", cfg_done, 1);
    check("t2_tx_count", tx_q.size(), 26);
    for (int i = 0; i < 26 && i < tx_q.size(); i++) check($sformatf("t2_byte%0d", i), tx_q[i], exp_script[i]);
    if (tx_cyc_q.size() == 26) check("t2_spacing", tx_cyc_q[25] - tx_cyc_q[0], 25 * 16);
    repeat (20) @(negedge clk);

    // 5a: stop while waiting on the ADC
    clear_q();
    pulse(1, 0);
    for (int i = 0; i < 100 && st_q.size() < 1; i++) @(negedge clk);
    repeat (5) @(posedge clk);
    pulse(0, 1);
    repeat (40) @(negedge clk);
    check("t5_conv_count", st_q.size(), 1);
    check("t5_no_sample", smp_q.size(), 0);
    check("t5_mux_held", mux_sel, 9'h140);
    check("t5_cfg_kept", cfg_done, 1);

    // start and stop together in IDLE: start wins
    pulse(1, 1);
    @(negedge clk);
    check("t5_start_wins_valid", tx_valid, 1);
    check("t5_start_wins_data", tx_data, 8'h01);

    // 5b: reset mid-config aborts immediately
    repeat (3) @(posedge clk);
    #3 rst = 1;
    @(negedge clk);
    check_reset("midrst");
    @(posedge clk); #1 rst = 0;
    repeat (5) @(negedge clk);
    check("t5_idle_after_rst", tx_valid, 0);

`ifndef MAX1452_UNLOCK_CTRL_EN
    check("t6_unlock_always_high", unlock_viol, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
